// File: rtl/clk_div_mode_ctrl.sv
// Output-clock divider mode controller: half-period counter with glitch-free ratio switching.
// Optional auto mode rotation is compiled in with `define CLKDIV_AUTO_SEQ_EN.
module clk_div_mode_ctrl #(
    parameter int unsigned HALF0     = 25_000_000,
    parameter int unsigned HALF1     = 12_500_000,
    parameter int unsigned HALF2     = 5_000_000,
    parameter int unsigned HALF3     = 2_500_000,
    parameter int unsigned CNT_W     = 25,
    parameter logic [1:0]  INIT_MODE = 2'b00,
    parameter int unsigned DWELL     = 4
) (
    input  logic       Clk50MHz,
    input  logic       Rst,
    input  logic       ReqValid,
    input  logic [1:0] ReqMode,
    output logic       ReqReady,
    input  logic       AutoEn,
    output logic       Clk,
    output logic [1:0] CurMode,
    output logic       SwitchDone
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic [1:0]       r_mode;
    logic [1:0]       r_pend_mode;
    logic             r_sd;

    logic [CNT_W-1:0] w_limit;
    logic             w_cnt_wrap;
    logic             w_boundary;
    logic             w_accept;
    logic [1:0]       w_mode_nxt;
    logic [1:0]       w_pend_nxt;
    logic             w_sd_nxt;
    logic             w_auto_step;

    function automatic logic [CNT_W-1:0] f_limit(input logic [1:0] mode);
        case (mode)
            2'd0:    f_limit = CNT_W'(HALF0);
            2'd1:    f_limit = CNT_W'(HALF1);
            2'd2:    f_limit = CNT_W'(HALF2);
            default: f_limit = CNT_W'(HALF3);
        endcase
    endfunction

`ifdef CLKDIV_AUTO_SEQ_EN
    localparam int unsigned PER_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [PER_W-1:0] r_per;
    logic             w_per_last;

    assign w_per_last = (r_per == PER_W'(DWELL - 1));
`else
    logic w_unused_auto;

    assign w_unused_auto = AutoEn & (DWELL != 0);
`endif

    // A period boundary is the high-to-low toggle; only there may the ratio change.
    assign w_limit    = f_limit(r_mode);
    assign w_cnt_wrap = (r_cnt == w_limit);
    assign w_boundary = w_cnt_wrap && r_clk;
    assign w_accept   = ReqValid && (r_state == ST_RUN);

    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pend_nxt  = r_pend_mode;
        w_sd_nxt    = 1'b0;
        w_auto_step = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (ReqMode != r_mode) begin
                        w_state_nxt = ST_PEND;
                        w_pend_nxt  = ReqMode;
                    end else begin
                        w_sd_nxt = 1'b1;
                    end
                end
`ifdef CLKDIV_AUTO_SEQ_EN
                else if (AutoEn && w_boundary && w_per_last) begin
                    w_auto_step = 1'b1;
                    w_mode_nxt  = r_mode + 2'd1;
                    w_sd_nxt    = 1'b1;
                end
`endif
            end
            ST_PEND: begin
                if (w_boundary) begin
                    w_state_nxt = ST_RUN;
                    w_mode_nxt  = r_pend_mode;
                    w_sd_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Mode changes land on the wrap edge, so the counter restart and low phase come for free.
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            r_cnt       <= CNT_W'(1);
            r_clk       <= 1'b0;
            r_mode      <= INIT_MODE;
            r_pend_mode <= INIT_MODE;
            r_sd        <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_wrap ? CNT_W'(1) : r_cnt + CNT_W'(1);
            r_clk       <= w_cnt_wrap ? ~r_clk : r_clk;
            r_mode      <= w_mode_nxt;
            r_pend_mode <= w_pend_nxt;
            r_sd        <= w_sd_nxt;
        end
    end

`ifdef CLKDIV_AUTO_SEQ_EN
    // Completed-period count; an accepted request on a boundary suppresses the auto step.
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            r_per <= '0;
        end else if (!AutoEn || w_auto_step || (r_state == ST_PEND && w_boundary)) begin
            r_per <= '0;
        end else if (r_state == ST_RUN && !w_accept && w_boundary) begin
            r_per <= r_per + PER_W'(1);
        end
    end
`endif

    assign ReqReady   = (r_state == ST_RUN) && !Rst;
    assign Clk        = r_clk;
    assign CurMode    = r_mode;
    assign SwitchDone = r_sd;

endmodule

// File: tb/tb_clk_div_mode_ctrl.sv
// Self-checking bench for clk_div_mode_ctrl: directed steps plus random traffic against a period-position model.
module tb_clk_div_mode_ctrl;

    localparam int unsigned DWELL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       auto_en;
    logic       req_ready;
    logic       clk_out;
    logic [1:0] cur_mode;
    logic       switch_done;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: position inside the current full period plus mode/pending bookkeeping.
    int lims [4] = '{4, 2, 3, 1};
    int m_pos;
    int m_mode;
    int m_pmode;
    int m_per;
    bit m_pend;
    bit m_sd;

    always #5 clk = ~clk;

    clk_div_mode_ctrl #(
        .HALF0     (4),
        .HALF1     (2),
        .HALF2     (3),
        .HALF3     (1),
        .CNT_W     (3),
        .INIT_MODE (2'b00),
        .DWELL     (DWELL)
    ) dut (
        .Clk50MHz   (clk),
        .Rst        (rst),
        .ReqValid   (req_valid),
        .ReqMode    (req_mode),
        .ReqReady   (req_ready),
        .AutoEn     (auto_en),
        .Clk        (clk_out),
        .CurMode    (cur_mode),
        .SwitchDone (switch_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        bit bnd;
        bnd  = (m_pos == 2 * lims[m_mode] - 1);
        m_sd = 1'b0;
        if (rst) begin
            m_pos  = 0;
            m_mode = 0;
            m_pend = 1'b0;
            m_per  = 0;
            return;
        end
        if (m_pend) begin
            if (bnd) begin
                m_mode = m_pmode;
                m_pend = 1'b0;
                m_sd   = 1'b1;
                m_per  = 0;
            end
        end else if (req_valid) begin
            if (int'(req_mode) != m_mode) begin
                m_pend  = 1'b1;
                m_pmode = int'(req_mode);
            end else begin
                m_sd = 1'b1;
            end
        end else if (bnd) begin
`ifdef CLKDIV_AUTO_SEQ_EN
            if (auto_en) begin
                m_per++;
                if (m_per == DWELL) begin
                    m_per  = 0;
                    m_mode = (m_mode + 1) % 4;
                    m_sd   = 1'b1;
                end
            end
`endif
        end
        if (!auto_en) m_per = 0;
        m_pos = bnd ? 0 : m_pos + 1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] m, input logic a);
        rst       = r;
        req_valid = v;
        req_mode  = m;
        auto_en   = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("clk_out",     32'(clk_out),     32'(m_pos >= lims[m_mode]));
        chk("cur_mode",    32'(cur_mode),    32'(m_mode));
        chk("req_ready",   32'(req_ready),   32'(!m_pend && !rst));
        chk("switch_done", 32'(switch_done), 32'(m_sd));
    endtask

    initial begin
        int         lat;
        logic       r;
        logic       v;
        logic       a;
        logic [1:0] m;

        m_pos = 0; m_mode = 0; m_pmode = 0; m_per = 0; m_pend = 1'b0; m_sd = 1'b0;

        repeat (3) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 2'd0, 1'b0);

        // Request mode 1 in the second cycle of a low phase; switch lands 6 edges after acceptance.
        for (int i = 0; i < 20 && m_pos != 1; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 1'b0);
            lat++;
            if (switch_done === 1'b1) break;
        end
        chk("switch_latency", 32'(lat), 32'd6);
        chk("mode_after_switch", 32'(cur_mode), 32'd1);
        repeat (12) cyc(1'b0, 1'b0, 2'd0, 1'b0);

        // Request 3, then hold ReqValid with mode 2 across the pending window.
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        repeat (14) cyc(1'b0, 1'b1, 2'd2, 1'b0);
        repeat (14) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("mode_after_held_req", 32'(cur_mode), 32'd2);

        // Same-mode request: immediate done pulse, no waveform disturbance.
        cyc(1'b0, 1'b1, 2'(m_mode), 1'b0);
        chk("same_mode_done", 32'(switch_done), 32'd1);
        repeat (8) cyc(1'b0, 1'b0, 2'd0, 1'b0);

        // Auto rotation (model is macro-aware).
        repeat (90) cyc(1'b0, 1'b0, 2'd0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 2'd0, 1'b0);

        // Reset in the high phase while a request is pending.
        for (int i = 0; i < 20 && m_pos != 0; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'((m_mode + 1) % 4), 1'b0);
        for (int i = 0; i < 20 && m_pos != lims[m_mode]; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        chk("rst_clk_low",   32'(clk_out),     32'd0);
        chk("rst_mode_init", 32'(cur_mode),    32'd0);
        chk("rst_no_done",   32'(switch_done), 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        chk("no_done_after_rst", 32'(switch_done), 32'd0);

        // Random traffic: sparse requests, occasional AutoEn toggles and resets.
        a = 1'b0;
        for (int i = 0; i < 700; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 5) == 0);
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) a = !a;
            cyc(r, v, m, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
